// File: rtl/axi_bandwidth_monitor_pkg.sv
// Shared widths, FSM state codes and default AXI channel structs for axi_bandwidth_monitor.
package axi_bandwidth_monitor_pkg;

  localparam int unsigned DefAxiIdWidth = 3;
  localparam int unsigned DefDataWidth  = 64;
  localparam int unsigned DefCntWidth   = 16;
  localparam int unsigned DefStatWidth  = 48;
  localparam int unsigned DefAddrWidth  = 32;

  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ST_IDLE    = 2'd0;
  localparam mon_state_t ST_MEASURE = 2'd1;
  localparam mon_state_t ST_FROZEN  = 2'd2;

  typedef struct packed {
    logic [DefAxiIdWidth-1:0] id;
    logic [DefAddrWidth-1:0]  addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [DefAxiIdWidth-1:0] id;
    logic [1:0]               resp;
  } b_chan_t;

  typedef struct packed {
    logic [DefAxiIdWidth-1:0] id;
    logic [DefDataWidth-1:0]  data;
    logic [1:0]               resp;
    logic                     last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

// File: rtl/axi_bandwidth_inflight_cnt.sv
// Per-ID up/down in-flight counter bank with a running total, saturation and underflow detection.
module axi_bandwidth_inflight_cnt #(
  parameter int unsigned IdWidth  = 3,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic [IdWidth-1:0]  inc_id_i,
  input  logic                dec_i,
  input  logic [IdWidth-1:0]  dec_id_i,
  output logic [CntWidth-1:0] total_o,
  output logic                err_o
);

  localparam int unsigned        NumIds = 1 << IdWidth;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [CntWidth-1:0] cnt_q [NumIds];
  logic pair_cancel, inc_sat, dec_under, inc_ok, dec_ok, tot_sat;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    pair_cancel = inc_i && dec_i && (inc_id_i == dec_id_i);
    inc_sat     = inc_i && !pair_cancel && (cnt_q[inc_id_i] == CntMax);
    dec_under   = dec_i && !pair_cancel && (cnt_q[dec_id_i] == '0);
    inc_ok      = inc_i && !pair_cancel && !inc_sat;
    dec_ok      = dec_i && !pair_cancel && !dec_under;
    tot_sat     = inc_ok && !dec_ok && (total_o == CntMax);
    err_o       = inc_sat || dec_under || tot_sat;
  end

  // NOTE: the per-ID bank is a small flop array, so it is reset like any other state; a RAM would not be.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumIds; i++) begin
      if (rst_i) begin
        cnt_q[i] <= '0;
      end else if (inc_ok && (inc_id_i == IdWidth'(i))) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end else if (dec_ok && (dec_id_i == IdWidth'(i))) begin
        cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_o <= '0;
    end else if (inc_ok && !dec_ok && !tot_sat) begin
      total_o <= total_o + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      total_o <= total_o - 1'b1;
    end
  end

endmodule

// File: rtl/axi_bandwidth_monitor.sv
// Passive AXI4 in-flight and bandwidth monitor with freeze-on-end-of-sim.
// Optional summary print on freeze: define AXI_BANDWIDTH_MONITOR_DISPLAY_EN.
module axi_bandwidth_monitor
  import axi_bandwidth_monitor_pkg::*;
#(
  parameter type         req_t      = axi_req_t,
  parameter type         rsp_t      = axi_rsp_t,
  parameter int unsigned AxiIdWidth = DefAxiIdWidth,
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned CntWidth   = DefCntWidth,
  parameter int unsigned StatWidth  = DefStatWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 end_of_sim_i,
  input  req_t                 req_i,
  input  rsp_t                 rsp_i,
  output logic [CntWidth-1:0]  ar_in_flight_o,
  output logic [CntWidth-1:0]  aw_in_flight_o,
  output logic [StatWidth-1:0] rd_bytes_o,
  output logic [StatWidth-1:0] wr_bytes_o,
  output logic [StatWidth-1:0] active_cycles_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [StatWidth-1:0] BytesPerBeat = StatWidth'(DataWidth / 8);

  logic ar_hs, r_hs, r_last_hs, aw_hs, w_hs, b_hs;
  logic rd_err, wr_err, stat_en;
  mon_state_t state_q, state_d;
  logic [StatWidth-1:0] rd_bytes_q, wr_bytes_q, active_q;
  logic err_q;

  assign ar_hs     = req_i.ar_valid && rsp_i.ar_ready;
  assign r_hs      = rsp_i.r_valid && req_i.r_ready;
  assign r_last_hs = r_hs && rsp_i.r.last;
  assign aw_hs     = req_i.aw_valid && rsp_i.aw_ready;
  assign w_hs      = req_i.w_valid && rsp_i.w_ready;
  assign b_hs      = rsp_i.b_valid && req_i.b_ready;

  axi_bandwidth_inflight_cnt #(.IdWidth(AxiIdWidth), .CntWidth(CntWidth)) u_rd_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (ar_hs),
    .inc_id_i (req_i.ar.id[AxiIdWidth-1:0]),
    .dec_i    (r_last_hs),
    .dec_id_i (rsp_i.r.id[AxiIdWidth-1:0]),
    .total_o  (ar_in_flight_o),
    .err_o    (rd_err)
  );

  axi_bandwidth_inflight_cnt #(.IdWidth(AxiIdWidth), .CntWidth(CntWidth)) u_wr_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (aw_hs),
    .inc_id_i (req_i.aw.id[AxiIdWidth-1:0]),
    .dec_i    (b_hs),
    .dec_id_i (rsp_i.b.id[AxiIdWidth-1:0]),
    .total_o  (aw_in_flight_o),
    .err_o    (wr_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_MEASURE: begin
        if (end_of_sim_i) state_d = ST_FROZEN;
        else if (en_i)    state_d = ST_MEASURE;
        else              state_d = ST_IDLE;
      end
      ST_FROZEN: state_d = ST_FROZEN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The freeze takes effect after the edge that samples end_of_sim_i, so that cycle still counts.
  assign stat_en = en_i && (state_q != ST_FROZEN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_bytes_q <= '0;
      wr_bytes_q <= '0;
      active_q   <= '0;
    end else if (stat_en) begin
      if (r_hs) rd_bytes_q <= rd_bytes_q + BytesPerBeat;
      if (w_hs) wr_bytes_q <= wr_bytes_q + BytesPerBeat;
      if ((ar_in_flight_o != '0) || (aw_in_flight_o != '0)) active_q <= active_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                err_q <= 1'b0;
    else if (rd_err || wr_err) err_q <= 1'b1;
  end

  assign rd_bytes_o      = rd_bytes_q;
  assign wr_bytes_o      = wr_bytes_q;
  assign active_cycles_o = active_q;
  assign done_o          = (state_q == ST_FROZEN);
  assign err_o           = err_q;

`ifdef AXI_BANDWIDTH_MONITOR_DISPLAY_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q != ST_FROZEN) && end_of_sim_i) begin
      $display("axi_bandwidth_monitor: rd %0d B/cyc, wr %0d B/cyc, ar_in_flight %0d, aw_in_flight %0d",
               (active_q == '0) ? '0 : rd_bytes_q / active_q,
               (active_q == '0) ? '0 : wr_bytes_q / active_q,
               ar_in_flight_o, aw_in_flight_o);
      if (err_q) $error("axi_bandwidth_monitor: protocol error observed during measurement");
    end
  end
`else
`endif

endmodule

// File: tb/tb_axi_bandwidth_monitor.sv
// Scoreboard bench for axi_bandwidth_monitor: driver pushes model predictions, monitor pops and compares.
module tb_axi_bandwidth_monitor;
  import axi_bandwidth_monitor_pkg::*;

  localparam int NumIds = 8;
  localparam int CntMax = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, eos;
  axi_req_t req;
  axi_rsp_t rsp;
  logic [15:0] ar_if, aw_if;
  logic [47:0] rd_b, wr_b, act;
  logic done, err;

  axi_bandwidth_monitor dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .end_of_sim_i    (eos),
    .req_i           (req),
    .rsp_i           (rsp),
    .ar_in_flight_o  (ar_if),
    .aw_in_flight_o  (aw_if),
    .rd_bytes_o      (rd_b),
    .wr_bytes_o      (wr_b),
    .active_cycles_o (act),
    .done_o          (done),
    .err_o           (err)
  );

  typedef struct {
    logic [15:0] ar, aw;
    logic [47:0] rd, wr, act;
    logic        done, err;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int miscompares = 0;

  // Stimulus for the next cycle; copied onto the DUT inputs at the negedge.
  bit s_rst, s_en, s_eos;
  bit s_ar_v, s_ar_r, s_r_v, s_r_r, s_r_last, s_aw_v, s_aw_r, s_w_v, s_w_r, s_b_v, s_b_r;
  logic [2:0] s_ar_id, s_r_id, s_aw_id, s_b_id;

  // Reference model: per-direction, per-ID outstanding counts (0 = read, 1 = write).
  int          m_cnt[2][NumIds];
  bit          m_err, m_frozen;
  logic [47:0] m_rd, m_wr, m_act;

  function automatic int total(int dir);
    int s = 0;
    for (int i = 0; i < NumIds; i++) s += m_cnt[dir][i];
    return s;
  endfunction

  function automatic void track(int dir, bit inc, int iid, bit dec, int did);
    if (inc && dec && iid == did) return;
    if (dec) begin
      if (m_cnt[dir][did] == 0) m_err = 1'b1;
      else m_cnt[dir][did]--;
    end
    if (inc) begin
      if (m_cnt[dir][iid] == CntMax) m_err = 1'b1;
      else m_cnt[dir][iid]++;
    end
  endfunction

  function automatic int pick_out(int dir);
    int ids[$];
    for (int i = 0; i < NumIds; i++) if (m_cnt[dir][i] > 0) ids.push_back(i);
    if (ids.size() == 0) return -1;
    return ids[$urandom_range(0, ids.size() - 1)];
  endfunction

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, n_vec, act_v, exp_v);
    end
  endtask

  task automatic idle();
    {s_rst, s_eos, s_ar_v, s_ar_r, s_r_v, s_r_r, s_r_last} = '0;
    {s_aw_v, s_aw_r, s_w_v, s_w_r, s_b_v, s_b_r} = '0;
    {s_ar_id, s_r_id, s_aw_id, s_b_id} = '0;
  endtask

  task automatic step();
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    exp_t e;
    @(negedge clk);
    rst = s_rst; en = s_en; eos = s_eos;
    req = '0; rsp = '0;
    req.ar.id = s_ar_id; req.ar.addr = $urandom; req.ar_valid = s_ar_v; rsp.ar_ready = s_ar_r;
    req.aw.id = s_aw_id; req.aw.addr = $urandom; req.aw_valid = s_aw_v; rsp.aw_ready = s_aw_r;
    req.w.data = {$urandom, $urandom}; req.w.strb = 8'($urandom); req.w_valid = s_w_v; rsp.w_ready = s_w_r;
    rsp.r.id = s_r_id; rsp.r.data = {$urandom, $urandom}; rsp.r.last = s_r_last;
    rsp.r_valid = s_r_v; req.r_ready = s_r_r;
    rsp.b.id = s_b_id; rsp.b_valid = s_b_v; req.b_ready = s_b_r;
    ar_hs = s_ar_v && s_ar_r; r_hs = s_r_v && s_r_r; aw_hs = s_aw_v && s_aw_r;
    w_hs = s_w_v && s_w_r; b_hs = s_b_v && s_b_r;
    if (s_rst) begin
      for (int d = 0; d < 2; d++) for (int i = 0; i < NumIds; i++) m_cnt[d][i] = 0;
      m_err = 0; m_frozen = 0; m_rd = '0; m_wr = '0; m_act = '0;
    end else begin
      if (s_en && !m_frozen) begin
        if (total(0) != 0 || total(1) != 0) m_act++;
        if (r_hs) m_rd += 48'd8;
        if (w_hs) m_wr += 48'd8;
      end
      track(0, ar_hs, int'(s_ar_id), r_hs && s_r_last, int'(s_r_id));
      track(1, aw_hs, int'(s_aw_id), b_hs, int'(s_b_id));
      if (s_eos) m_frozen = 1'b1;
    end
    e.ar = 16'(total(0)); e.aw = 16'(total(1));
    e.rd = m_rd; e.wr = m_wr; e.act = m_act; e.done = m_frozen; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    idle(); s_rst = 1'b1;
    repeat (n) step();
    s_rst = 1'b0;
  endtask

  // Monitor: the prediction pushed before an edge is compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        check("ar_in_flight", 64'(ar_if), 64'(e.ar));
        check("aw_in_flight", 64'(aw_if), 64'(e.aw));
        check("rd_bytes", 64'(rd_b), 64'(e.rd));
        check("wr_bytes", 64'(wr_b), 64'(e.wr));
        check("active_cycles", 64'(act), 64'(e.act));
        check("done", 64'(done), 64'(e.done));
        check("err", 64'(err), 64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    rst = 1'b1; en = 1'b0; eos = 1'b0; req = '0; rsp = '0;
    idle(); s_en = 1'b0;

    // Four ARs on ID 2, no responses.
    reset_cycles(2);
    s_ar_v = 1; s_ar_r = 1; s_ar_id = 3'd2;
    repeat (4) step();
    idle(); repeat (2) step();

    // AR and final R on the same ID in one cycle leave the count unchanged.
    reset_cycles(1);
    s_ar_v = 1; s_ar_r = 1; s_ar_id = 3'd1; step();
    s_r_v = 1; s_r_r = 1; s_r_id = 3'd1; s_r_last = 1; step();
    idle(); step();

    // One write burst of 8 beats while enabled.
    reset_cycles(1);
    s_en = 1'b1;
    s_aw_v = 1; s_aw_r = 1; s_aw_id = 3'd0; step();
    idle(); s_w_v = 1; s_w_r = 1;
    repeat (8) step();
    idle(); s_b_v = 1; s_b_r = 1; s_b_id = 3'd0; step();
    idle(); repeat (2) step();

    // B with nothing outstanding: sticky error, count stays at 0.
    s_b_v = 1; s_b_r = 1; s_b_id = 3'd3; step();
    idle(); repeat (3) step();

    // Randomized traffic; responses only target outstanding IDs.
    reset_cycles(1);
    for (int c = 0; c < 400; c++) begin
      idle();
      s_en = ($urandom_range(0, 9) != 0);
      s_ar_v = 1'($urandom_range(0, 1)); s_ar_r = 1'($urandom_range(0, 1));
      s_ar_id = 3'($urandom_range(0, 7));
      s_aw_v = 1'($urandom_range(0, 1)); s_aw_r = 1'($urandom_range(0, 1));
      s_aw_id = 3'($urandom_range(0, 7));
      s_w_v = 1'($urandom_range(0, 1)); s_w_r = 1'($urandom_range(0, 1));
      id = pick_out(0);
      if (id >= 0) begin
        s_r_v = 1'($urandom_range(0, 1)); s_r_r = 1'($urandom_range(0, 1));
        s_r_id = 3'(id); s_r_last = 1'($urandom_range(0, 1));
      end
      id = pick_out(1);
      if (id >= 0) begin
        s_b_v = 1'($urandom_range(0, 1)); s_b_r = 1'($urandom_range(0, 1));
        s_b_id = 3'(id);
      end
      step();
    end

    // Freeze with an R beat in the same cycle, then 10 more R beats.
    reset_cycles(1);
    s_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(); s_ar_v = 1; s_ar_r = 1; s_ar_id = 3'(i); step();
    end
    idle(); s_eos = 1; s_r_v = 1; s_r_r = 1; s_r_id = 3'd0; step();
    for (int i = 0; i < 10; i++) begin
      idle(); s_r_v = 1; s_r_r = 1; s_r_id = 3'(i % 3); s_r_last = (i >= 7);
      if (i == 4) begin s_ar_v = 1; s_ar_r = 1; s_ar_id = 3'd5; end
      step();
    end
    idle(); repeat (2) step();

    // Reset in the middle of a read burst with 3 reads outstanding.
    reset_cycles(1);
    for (int i = 0; i < 3; i++) begin
      idle(); s_ar_v = 1; s_ar_r = 1; s_ar_id = 3'(4 + i); step();
    end
    idle(); s_r_v = 1; s_r_r = 1; s_r_id = 3'd4;
    repeat (2) step();
    s_rst = 1'b1; step();
    idle(); repeat (2) step();

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
